// File: rtl/nand_gate.sv
// Two-input bitwise NAND with a combinational output, a valid-qualified registered
// copy, and a saturating count of captures that changed the registered value.
module nand_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] w_nand;
  logic             w_changed;
  logic             w_cnt_max;

  logic [WIDTH-1:0] r_c_q;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_toggle_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
      assign w_nand[gi] = ~(a[gi] & b[gi]);
    end
  endgenerate

  // A toggle is judged against the value held before this edge.
  assign w_changed = |(w_nand ^ r_c_q);
  assign w_cnt_max = &r_toggle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_q        <= '1;
      r_out_valid  <= 1'b0;
      r_toggle_cnt <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_c_q <= w_nand;
        if (w_changed && !w_cnt_max) begin
          r_toggle_cnt <= r_toggle_cnt + 1'b1;
        end
      end
    end
  end

  assign c          = w_nand;
  assign c_q        = r_c_q;
  assign out_valid  = r_out_valid;
  assign toggle_cnt = r_toggle_cnt;

endmodule

// File: tb/tb_nand_gate.sv
// Directed-vector bench for nand_gate: 1-bit, 8-bit and a 2-bit-counter instance
// share clock and reset; each check is against hand-computed values.
module tb_nand_gate;

  logic       clk;
  logic       rst;

  logic       a1, b1, v1;
  logic       c1, cq1, ov1;
  logic [7:0] cnt1;

  logic [7:0] a8, b8;
  logic       v8;
  logic [7:0] c8, cq8;
  logic       ov8;
  logic [7:0] cnt8;

  logic       as, bs, vs;
  logic       cs, cqs, ovs;
  logic [1:0] cnts;

  int n_vec;
  int n_err;

  nand_gate #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .c(c1), .c_q(cq1), .out_valid(ov1), .toggle_cnt(cnt1)
  );

  nand_gate #(.WIDTH(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
    .c(c8), .c_q(cq8), .out_valid(ov8), .toggle_cnt(cnt8)
  );

  nand_gate #(.WIDTH(1), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .a(as), .b(bs), .in_valid(vs),
    .c(cs), .c_q(cqs), .out_valid(ovs), .toggle_cnt(cnts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_ab   [4];
  logic       tt_c    [4];
  logic [1:0] sat_cnt [6];

  initial begin
    n_vec = 0;
    n_err = 0;
    tt_ab[0] = 2'b00; tt_ab[1] = 2'b01; tt_ab[2] = 2'b10; tt_ab[3] = 2'b11;
    tt_c[0]  = 1'b1;  tt_c[1]  = 1'b1;  tt_c[2]  = 1'b1;  tt_c[3]  = 1'b0;
    sat_cnt[0] = 2'd1; sat_cnt[1] = 2'd2; sat_cnt[2] = 2'd3;
    sat_cnt[3] = 2'd3; sat_cnt[4] = 2'd3; sat_cnt[5] = 2'd3;

    rst = 1'b1;
    a1 = 0; b1 = 0; v1 = 0;
    a8 = 0; b8 = 0; v8 = 0;
    as = 0; bs = 0; vs = 0;
    #1;
    chk("rst_cq", cq1, 1);
    chk("rst_ov", ov1, 0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_cq8", cq8, 8'hFF);

    // in_valid while reset is held must be ignored
    v1 = 1; a1 = 1; b1 = 1;
    tick();
    chk("rsthold_cq", cq1, 1);
    chk("rsthold_ov", ov1, 0);
    v1 = 0; a1 = 0; b1 = 0;
    @(negedge clk);
    rst = 1'b0;

    // combinational truth table, 10 time units per vector
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = tt_ab[i];
      #10;
      chk($sformatf("tt_c_%0d", i), c1, tt_c[i]);
    end

    // registered truth table, one vector per clock
    @(negedge clk);
    v1 = 1;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = tt_ab[i];
      tick();
      chk($sformatf("tt_cq_%0d", i), cq1, tt_c[i]);
      chk($sformatf("tt_ov_%0d", i), ov1, 1);
    end
    chk("tt_cnt", cnt1, 1);

    // build up toggle_cnt to 5 with c_q = 0: 00,11,00,11 adds four toggles
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = (i % 2 == 0) ? 2'b00 : 2'b11;
      tick();
    end
    chk("pre_rst_cq", cq1, 0);
    chk("pre_rst_cnt", cnt1, 5);

    // idle: inputs change, registered state holds
    v1 = 0;
    a1 = 0; b1 = 1;
    tick();
    chk("idle_ov", ov1, 0);
    chk("idle_cq", cq1, 0);
    chk("idle_cnt", cnt1, 5);
    chk("idle_c", c1, 1);
    a1 = 1; b1 = 1;
    tick();
    chk("idle_cq2", cq1, 0);
    chk("idle_c2", c1, 0);

    // asynchronous reset away from any clock edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cq", cq1, 1);
    chk("arst_ov", ov1, 0);
    chk("arst_cnt", cnt1, 0);
    chk("arst_c", c1, 0);
    a1 = 0;
    #1;
    chk("arst_c_track", c1, 1);
    @(negedge clk);
    rst = 1'b0;

    // first capture of 00 after reset is not a toggle
    v1 = 1; a1 = 0; b1 = 0;
    tick();
    chk("first00_cnt", cnt1, 0);
    chk("first00_ov", ov1, 1);
    v1 = 0;
    tick();
    chk("pulse_ov", ov1, 0);

    // multi-bit
    a8 = 8'hF0; b8 = 8'h3C;
    #1;
    chk("w8_c", c8, 8'hCF);
    v8 = 1;
    tick();
    v8 = 0;
    chk("w8_cq", cq8, 8'hCF);
    chk("w8_ov", ov8, 1);
    chk("w8_cnt", cnt8, 1);

    // saturation with a 2-bit counter
    @(negedge clk);
    vs = 1;
    for (int i = 0; i < 6; i++) begin
      {as, bs} = (i % 2 == 0) ? 2'b11 : 2'b00;
      tick();
      chk($sformatf("sat_cnt_%0d", i), cnts, sat_cnt[i]);
      chk($sformatf("sat_cq_%0d", i), cqs, (i % 2 == 0) ? 1'b0 : 1'b1);
    end
    vs = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
